// File: rtl/soc_mem_arbiter.sv
// soc_mem_arbiter: two-master, one-slave valid/ready bus arbiter with
// round-robin fairness and a BUSY-cycle watchdog that forces an error reply.
// Ports:
//   clk, reset          : clock, async active-high reset
//   m0_* / m1_*         : master request (valid/addr/wdata/wstrb) and reply
//                         (ready pulse, rdata, err)
//   s_*                 : slave request (valid/addr/wdata/wstrb), reply (ready/rdata)
//   grant               : one-hot owner of the current transaction, 00 when idle
module soc_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_err,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_err,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          grant
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t      state;
  state_t      state_n;
  logic        last_g;
  logic [15:0] cnt;
  logic        req;
  logic        pick1;
  logic        tmo;
  logic        fin;

  always_comb begin
    req     = m0_valid | m1_valid;
    // m1 wins when alone, or on a tie when m0 owned the bus last
    pick1   = m1_valid & (~m0_valid | ~last_g);
    tmo     = (TIMEOUT != 0) && (cnt == 16'(TIMEOUT - 1));
    fin     = s_ready | tmo;
    state_n = state;
    unique case (state)
      IDLE:    if (req) state_n = BUSY;
      BUSY:    if (fin) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_valid  <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_wstrb  <= '0;
      grant    <= 2'b00;
      m0_ready <= 1'b0;
      m0_rdata <= '0;
      m0_err   <= 1'b0;
      m1_ready <= 1'b0;
      m1_rdata <= '0;
      m1_err   <= 1'b0;
      last_g   <= 1'b1;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            s_valid <= 1'b1;
            grant   <= pick1 ? 2'b10 : 2'b01;
            s_addr  <= pick1 ? m1_addr : m0_addr;
            s_wdata <= pick1 ? m1_wdata : m0_wdata;
            s_wstrb <= pick1 ? m1_wstrb : m0_wstrb;
            cnt     <= '0;
          end
        end
        BUSY: begin
          if (fin) begin
            s_valid <= 1'b0;
            last_g  <= grant[1];
            // a slave reply in the timeout cycle still counts as success
            if (grant[1]) begin
              m1_ready <= 1'b1;
              m1_err   <= ~s_ready;
              m1_rdata <= s_ready ? s_rdata : '1;
            end else begin
              m0_ready <= 1'b1;
              m0_err   <= ~s_ready;
              m0_rdata <= s_ready ? s_rdata : '1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          m0_ready <= 1'b0;
          m0_err   <= 1'b0;
          m1_ready <= 1'b0;
          m1_err   <= 1'b0;
          grant    <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/soc_mem_arbiter.md
Name: soc_mem_arbiter

Overview:
- Two-master, one-slave memory bus arbiter for the picoSoC top. Shares the single on-chip memory/peripheral bus between the processor (m0) and a second requester (m1, DMA/debug loader).
- Uses picorv32-style valid/ready handshake on all ports, round-robin fairness, and a bus-timeout watchdog that returns an error response when the slave never answers.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- TIMEOUT, 255, BUSY cycles allowed before forced error response; 0 disables the watchdog; max 65535.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- m0_valid  input  1  master 0 request; held high until m0_ready.
- m0_addr  input  ADDR_W  master 0 address.
- m0_wdata  input  DATA_W  master 0 write data.
- m0_wstrb  input  DATA_W/8  master 0 byte strobes; 0 = read.
- m0_ready  output  1  master 0 one-cycle completion pulse.
- m0_rdata  output  DATA_W  master 0 read data, valid with m0_ready.
- m0_err  output  1  master 0 timeout error flag, valid with m0_ready.
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata, m1_err: same as m0_*, for master 1.
- s_valid  output  1  slave request.
- s_addr  output  ADDR_W  slave address.
- s_wdata  output  DATA_W  slave write data.
- s_wstrb  output  DATA_W/8  slave byte strobes.
- s_ready  input  1  slave completion.
- s_rdata  input  DATA_W  slave read data.
- grant  output  2  one-hot owner of the current transaction; 00 when idle.

Behaviour:
- Reset values (asynchronous):
  - state = IDLE.
  - All outputs 0: s_valid, s_addr, s_wdata, s_wstrb, grant, mX_ready, mX_rdata, mX_err.
  - last_grant = m1, so m0 wins the first tie.
  - Timeout counter = 0.
- All outputs are registered.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Neither valid: stay in IDLE.
  - One valid: grant that master.
  - Both valid: grant the master that is not last_grant.
  - On grant, at the next edge:
    - Capture the master's addr/wdata/wstrb into s_addr/s_wdata/s_wstrb.
    - Set s_valid=1, grant to one-hot, counter=0, state=BUSY.
- BUSY:
  - s_valid is held high; captured fields are stable.
  - Master input changes are ignored until the next grant.
  - s_ready=1: at the next edge:
    - s_valid=0.
    - mX_rdata=s_rdata, mX_ready=1, mX_err=0 for the granted master.
    - last_grant=grant, state=RESP.
  - s_ready=0 with TIMEOUT!=0 and counter==TIMEOUT-1: at the next edge:
    - s_valid=0.
    - mX_ready=1, mX_err=1, mX_rdata={DATA_W{1'b1}}.
    - last_grant=grant, state=RESP.
  - Otherwise the counter increments.
  - s_ready and timeout in the same cycle: s_ready wins, err=0.
- RESP:
  - mX_ready/mX_err are high for exactly this cycle.
  - Next edge: ready/err cleared, grant=00, state=IDLE.
  - mX_rdata holds its value until the next response to that master.
- Latency:
  - m_valid (IDLE) to s_valid: 1 cycle.
  - s_ready to m_ready: 1 cycle.
  - Minimum request-to-ready: 2 cycles.
  - Minimum back-to-back issue spacing: 3 cycles.
- Requests arriving in BUSY/RESP wait; the non-granted master's ready stays 0.
- s_ready outside BUSY is ignored.
- A master dropping valid mid-transaction (protocol violation) does not abort the transaction; its response pulse is still issued.
- Reset mid-transaction aborts immediately:
  - s_valid drops asynchronously.
  - No ready pulse is issued to the master.
- Only the granted master's ready/err/rdata change; the other master's outputs are untouched.

Test Plan:
- Reset, then m0 read addr 0x0000_0010, slave returns s_rdata 0x1234_5678 with s_ready in the first BUSY cycle -> s_valid high 1 cycle; m0_ready pulses 2 cycles after m0_valid with m0_rdata=0x1234_5678, m0_err=0, grant=01 during BUSY.
- m0 and m1 assert valid in the same IDLE cycle, then both keep re-requesting for 4 transactions -> grant order m0, m1, m0, m1; each m1 request waits for the prior m0 response (RESP then IDLE) before s_valid.
- m1 write addr 0x2000_0004, wdata 0xCAFE_F00D, wstrb 4'b0011; change m1_addr to 0xFFFF_FFFF during BUSY; slave ready after 5 cycles -> s_addr/s_wdata/s_wstrb remain 0x2000_0004/0xCAFE_F00D/0011 throughout; m1_ready pulses once.
- TIMEOUT=8, m0 read, s_ready never asserted -> s_valid falls after 8 BUSY cycles; m0_ready=1, m0_err=1, m0_rdata=0xFFFF_FFFF for one cycle. Repeat with s_ready asserted exactly in the 8th BUSY cycle -> m0_err=0, data from the slave.
- Assert reset 2 cycles into a BUSY m1 transaction -> s_valid, grant, m1_ready all 0 immediately. After release, simultaneous m0/m1 requests -> m0 granted first.
- TIMEOUT=0, slave stalls 1000 cycles then readies -> no error; m0_ready arrives 1 cycle after s_ready.
